// File: rtl/nn_pkg.sv
// Shared types and Q16.16 arithmetic helpers for the neural-network layer blocks.
package nn_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int FRAC_BITS_DEF = 16;
  localparam int PROD_W        = 2 * DATA_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Full-precision signed product, rescaled back to Q16.16 and truncated.
  function automatic logic [DATA_W_DEF-1:0] q_mul(
    input logic signed [DATA_W_DEF-1:0] a,
    input logic signed [DATA_W_DEF-1:0] b,
    input int unsigned                  frac
  );
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    prod    = PROD_W'(a) * PROD_W'(b);
    shifted = prod >>> frac;
    return shifted[DATA_W_DEF-1:0];
  endfunction

  function automatic logic [DATA_W_DEF-1:0] relu(
    input logic [DATA_W_DEF-1:0] x,
    input logic                  en
  );
    logic [DATA_W_DEF-1:0] r;
    if (en && x[DATA_W_DEF-1]) begin
      r = '0;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Shared multiply-accumulate datapath: bias load, product accumulation and the
// activation stage, with the activated value held in a register.
module mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter bit ACT_RELU  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_bias,
  input  logic              accumulate,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] in_word,
  input  logic [DATA_W-1:0] w_word,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] prod_s;

  // result_q always mirrors act(acc_q), so the output is ready the cycle acc settles.
  always_comb begin
    prod_s = q_mul(in_word, w_word, FRAC_BITS);
    acc_d  = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (load_bias) begin
      acc_d = bias;
    end else if (accumulate) begin
      acc_d = acc_q + prod_s;
    end else begin
      acc_d = acc_q;
    end
    result_d = relu(acc_d, ACT_RELU);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/layer_sequencer.sv
// Fully connected layer evaluated one neuron at a time on a single MAC,
// reading inputs, weights and biases from external synchronous ROMs.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACT_RELU  = 1,
  localparam int IN_AW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int W_AW   = (NUM_IN * NUM_OUT > 1) ? $clog2(NUM_IN * NUM_OUT) : 1,
  localparam int OUT_AW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic [OUT_AW-1:0] b_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_AW-1:0] out_idx,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(NUM_IN - 1);
  localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(NUM_OUT - 1);

  state_t            state_q, state_d;
  logic [IN_AW-1:0]  i_q, i_d;
  logic [OUT_AW-1:0] j_q, j_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              out_valid_q, out_valid_d;
  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic [OUT_AW-1:0] b_addr_q, b_addr_d;
  logic [OUT_AW-1:0] out_idx_q, out_idx_d;
  logic [31:0]       w_idx_s;
  logic              clear_s, load_bias_s, accumulate_s;

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BIAS;
          j_d     = '0;
          clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BIAS: begin
        state_d = ST_MAC;
        i_d     = '0;
      end
      ST_MAC: begin
        if (i_q == I_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          i_d = i_q + IN_AW'(1);
        end
      end
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT: begin
        if (out_valid_q && out_ready) begin
          if (j_q == J_LAST) begin
            state_d = ST_DONE;
          end else begin
            j_d     = j_q + OUT_AW'(1);
            state_d = ST_BIAS;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    rd_en_d     = (state_d == ST_BIAS) || (state_d == ST_MAC);
    out_valid_d = (state_d == ST_EMIT);
    out_idx_d   = out_valid_d ? j_d : '0;
    w_idx_s     = 32'(j_d) * 32'(NUM_IN) + 32'(i_d);
    if (rd_en_d) begin
      in_addr_d = i_d;
      w_addr_d  = w_idx_s[W_AW-1:0];
      b_addr_d  = j_d;
    end else begin
      in_addr_d = '0;
      w_addr_d  = '0;
      b_addr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      in_addr_q   <= in_addr_d;
      w_addr_q    <= w_addr_d;
      b_addr_q    <= b_addr_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // ROM data lags the address by a cycle: the first MAC cycle sees the bias.
  assign load_bias_s  = (state_q == ST_MAC) && (i_q == '0);
  assign accumulate_s = ((state_q == ST_MAC) && (i_q != '0)) || (state_q == ST_DRAIN);

  mac_unit #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .ACT_RELU  (ACT_RELU != 0)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_s),
    .load_bias  (load_bias_s),
    .accumulate (accumulate_s),
    .bias       (b_data),
    .in_word    (in_data),
    .w_word     (w_data),
    .result     (out_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = b_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: ReLU on/off 2x2 layers and a 1-input wrap case.
module tb_layer_sequencer;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // DUT A: NUM_IN=2, NUM_OUT=2, ReLU on. DUT B: same, ReLU off (shares start).
  logic        a_start, a_busy, a_done, a_rd_en, a_out_valid, a_out_ready;
  logic [0:0]  a_in_addr, a_b_addr, a_out_idx;
  logic [1:0]  a_w_addr;
  logic [31:0] a_in_data, a_w_data, a_b_data, a_out_data;
  logic        b_busy, b_done, b_rd_en, b_out_valid, b_out_ready;
  logic [0:0]  b_in_addr, b_b_addr, b_out_idx;
  logic [1:0]  b_w_addr;
  logic [31:0] b_in_data, b_w_data, b_b_data, b_out_data;
  // DUT C: NUM_IN=1, NUM_OUT=2, ReLU off.
  logic        c_start, c_busy, c_done, c_rd_en, c_out_valid, c_out_ready;
  logic [0:0]  c_in_addr, c_w_addr, c_b_addr, c_out_idx;
  logic [31:0] c_in_data, c_w_data, c_b_data, c_out_data;

  logic [31:0] rom_in [0:1];
  logic [31:0] rom_w  [0:3];
  logic [31:0] rom_b  [0:1];
  logic [31:0] crom_in [0:1];
  logic [31:0] crom_w  [0:1];
  logic [31:0] crom_b  [0:1];

  layer_sequencer #(.NUM_IN(2), .NUM_OUT(2), .DATA_W(32), .FRAC_BITS(16), .ACT_RELU(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .in_addr(a_in_addr), .w_addr(a_w_addr), .b_addr(a_b_addr),
    .in_data(a_in_data), .w_data(a_w_data), .b_data(a_b_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx), .out_data(a_out_data));

  layer_sequencer #(.NUM_IN(2), .NUM_OUT(2), .DATA_W(32), .FRAC_BITS(16), .ACT_RELU(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .in_addr(b_in_addr), .w_addr(b_w_addr), .b_addr(b_b_addr),
    .in_data(b_in_data), .w_data(b_w_data), .b_data(b_b_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx), .out_data(b_out_data));

  layer_sequencer #(.NUM_IN(1), .NUM_OUT(2), .DATA_W(32), .FRAC_BITS(16), .ACT_RELU(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
    .rd_en(c_rd_en), .in_addr(c_in_addr), .w_addr(c_w_addr), .b_addr(c_b_addr),
    .in_data(c_in_data), .w_data(c_w_data), .b_data(c_b_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_idx(c_out_idx), .out_data(c_out_data));

  // Synchronous ROM models: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (a_rd_en) begin
      a_in_data <= rom_in[a_in_addr];
      a_w_data  <= rom_w[a_w_addr];
      a_b_data  <= rom_b[a_b_addr];
    end
    if (b_rd_en) begin
      b_in_data <= rom_in[b_in_addr];
      b_w_data  <= rom_w[b_w_addr];
      b_b_data  <= rom_b[b_b_addr];
    end
    if (c_rd_en) begin
      c_in_data <= crom_in[c_in_addr];
      c_w_data  <= crom_w[c_w_addr];
      c_b_data  <= crom_b[c_b_addr];
    end
  end

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   a_base, c_base, a_done_cyc, c_done_cyc;
  bit   a_active = 1'b0;
  bit   c_active = 1'b0;
  bit   a_done_seen, b_done_seen, c_done_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon_a
    int   cyc;
    exp_t e;
    cyc = ecnt - a_base;
    if (a_active) begin
      chk("a_busy", a_busy, (cyc >= 1 && cyc <= a_done_cyc));
      if (a_out_valid) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_out", 1, 0);
        end else begin
          e = qa[0];
          chk("a_out_idx", a_out_idx, e.idx);
          chk("a_out_data", a_out_data, e.data);
          if (a_out_ready) begin
            chk("a_accept_cyc", cyc, e.cyc);
            void'(qa.pop_front());
          end else begin
            chk("a_rd_en_stall", a_rd_en, 0);
          end
        end
      end
      if (a_done) begin
        chk("a_done_cyc", cyc, a_done_cyc);
        a_done_seen = 1'b1;
      end
    end else if (a_done) begin
      chk("a_spurious_done", 1, 0);
    end
  end

  always @(negedge clk) begin : mon_b
    int   cyc;
    exp_t e;
    cyc = ecnt - a_base;
    if (a_active) begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_out", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_out_idx", b_out_idx, e.idx);
          chk("b_out_data", b_out_data, e.data);
          chk("b_accept_cyc", cyc, e.cyc);
        end
      end
      if (b_done) begin
        chk("b_done_cyc", cyc, 11);
        b_done_seen = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : mon_c
    int   cyc;
    exp_t e;
    cyc = ecnt - c_base;
    if (c_active) begin
      chk("c_busy", c_busy, (cyc >= 1 && cyc <= c_done_cyc));
      if (c_out_valid && c_out_ready) begin
        if (qc.size() == 0) begin
          chk("c_unexpected_out", 1, 0);
        end else begin
          e = qc.pop_front();
          chk("c_out_idx", c_out_idx, e.idx);
          chk("c_out_data", c_out_data, e.data);
          chk("c_accept_cyc", cyc, e.cyc);
        end
      end
      if (c_done) begin
        chk("c_done_cyc", cyc, c_done_cyc);
        c_done_seen = 1'b1;
      end
    end else if (c_done) begin
      chk("c_spurious_done", 1, 0);
    end
  end

  // One layer run on A and B; optional stray start pulse and A-side backpressure.
  task automatic run_ab(input int pulse_cyc, input bit stall);
    int n_cyc;
    qa.push_back('{idx: 0, data: 32'h0001_4000, cyc: stall ? 9 : 5});
    qa.push_back('{idx: 1, data: 32'h0000_0000, cyc: stall ? 18 : 10});
    qb.push_back('{idx: 0, data: 32'h0001_4000, cyc: 5});
    qb.push_back('{idx: 1, data: 32'hFFFF_8000, cyc: 10});
    a_done_cyc  = stall ? 19 : 11;
    a_done_seen = 1'b0;
    b_done_seen = 1'b0;
    n_cyc       = a_done_cyc + 2;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    a_base   = ecnt - 1;
    a_active = 1'b1;
    for (int k = 2; k <= n_cyc; k++) begin
      @(posedge clk); #1;
      a_start     = (k == pulse_cyc);
      a_out_ready = !(stall && ((k >= 5 && k <= 8) || (k >= 14 && k <= 17)));
    end
    a_active    = 1'b0;
    a_out_ready = 1'b1;
    chk("a_done_seen", a_done_seen, 1);
    chk("b_done_seen", b_done_seen, 1);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    rom_in[0] = 32'h0001_0000; rom_in[1] = 32'h0002_0000;
    rom_w[0]  = 32'h0000_8000; rom_w[1]  = 32'h0000_4000;
    rom_w[2]  = 32'hFFFF_0000; rom_w[3]  = 32'h0000_0000;
    rom_b[0]  = 32'h0000_4000; rom_b[1]  = 32'h0000_8000;
    crom_in[0] = 32'h7FFF_0000; crom_in[1] = 32'h0000_0000;
    crom_w[0]  = 32'h0002_0000; crom_w[1]  = 32'h0001_0000;
    crom_b[0]  = 32'h0000_0000; crom_b[1]  = 32'h0001_0000;
    rst_n = 1'b0;
    a_start = 1'b0; c_start = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_idx", a_out_idx, 0);
    chk("rst_out_data", a_out_data, 0);

    run_ab(0, 1'b0);   // basic, ReLU on/off
    run_ab(3, 1'b0);   // start while busy is ignored
    run_ab(0, 1'b1);   // backpressure on A

    // Abort a run with reset in cycle 3 (second MAC cycle).
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_rd_en", a_rd_en, 0);
    chk("mid_rst_w_addr", a_w_addr, 0);
    chk("mid_rst_out_data", a_out_data, 0);
    chk("mid_rst_b_busy", b_busy, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    run_ab(0, 1'b0);   // fresh run after reset

    // NUM_IN=1: 4-cycle neurons, product wraps in the accumulator.
    qc.push_back('{idx: 0, data: 32'hFFFE_0000, cyc: 4});
    qc.push_back('{idx: 1, data: 32'h8000_0000, cyc: 8});
    c_done_cyc  = 9;
    c_done_seen = 1'b0;
    @(posedge clk); #1 c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    c_base   = ecnt - 1;
    c_active = 1'b1;
    repeat (11) @(posedge clk);
    #1 c_active = 1'b0;
    chk("c_done_seen", c_done_seen, 1);
    chk("c_queue_empty", qc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Time-multiplexes one Q16.16 multiply-accumulate datapath across all NUM_OUT neurons of a fully connected layer.
- Replaces the fully parallel neuron array when area matters.
- Fetches input, weight and bias words from external synchronous ROMs, accumulates each neuron's dot product plus bias, and applies an optional ReLU.
- Emits one result per neuron over a valid/ready stream; start/busy/done handshake toward the network-level controller.

Parameters:
- NUM_IN, 4, inputs per neuron (>=1)
- NUM_OUT, 4, neurons in the layer (>=1)
- DATA_W, 32, word width, signed Q16.16
- FRAC_BITS, 16, fractional bits
- ACT_RELU, 1, 1 = clamp negative results to 0; 0 = pass through

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin layer evaluation (sampled only in IDLE)
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the last result has been accepted
- rd_en  out  1  read strobe shared by all three ROMs
- in_addr  out  clog2(NUM_IN) (min 1)  input vector index
- w_addr  out  clog2(NUM_IN*NUM_OUT) (min 1)  weight index, neuron j, input i = j*NUM_IN+i
- b_addr  out  clog2(NUM_OUT) (min 1)  bias index
- in_data  in  DATA_W  input word, valid 1 cycle after rd_en
- w_data  in  DATA_W  weight word, valid 1 cycle after rd_en
- b_data  in  DATA_W  bias word, valid 1 cycle after rd_en
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_idx  out  clog2(NUM_OUT) (min 1)  neuron index of result
- out_data  out  DATA_W  activated result

Behaviour:
- Reset (async, any state): state IDLE; counters and accumulator cleared; all outputs 0.
- IDLE: busy=0. If start=1, clear neuron counter j and go to BIAS. start in any other state is ignored.
- BIAS (1 cycle): rd_en=1, b_addr=j. Next state MAC with i=0.
- MAC (NUM_IN cycles):
  - rd_en=1, in_addr=i, w_addr=j*NUM_IN+i; i increments each cycle.
  - First MAC cycle: acc <= b_data.
  - Later cycles: acc += product of the word issued the previous cycle.
  - After i=NUM_IN-1 is issued, go to DRAIN.
- DRAIN (1 cycle): rd_en=0; accumulate the last product.
- EMIT:
  - out_valid=1, out_idx=j, out_data=act(acc).
  - Hold while out_ready=0; out_data and out_idx must stay stable.
  - On out_valid&&out_ready: if j==NUM_OUT-1 go to DONE, else j++ and go to BIAS.
- DONE (1 cycle): done=1, busy=1; then IDLE.
- rd_en is 0 outside BIAS/MAC; address outputs are don't-care when rd_en=0.
- Arithmetic:
  - product = (signed 64-bit in_data*w_data) >>> FRAC_BITS, truncated to DATA_W.
  - Accumulation is 32-bit two's-complement wrap; no saturation.
  - act(x) = (ACT_RELU && x[31]) ? 0 : x.
- Timing (out_ready held 1):
  - Each neuron takes NUM_IN+3 cycles.
  - With start sampled at edge 0, neuron j occupies cycles j*(NUM_IN+3)+1 .. (j+1)*(NUM_IN+3).
  - done is high in cycle NUM_OUT*(NUM_IN+3)+1.
- NUM_IN=1: MAC lasts one cycle, loading only the bias; the single product is added in DRAIN.
- Backpressure never causes ROM re-reads; no new neuron starts until the current result is accepted.

Decomposition:
- Package nn_pkg: DATA_W and FRAC_BITS defaults, state enum (IDLE, BIAS, MAC, DRAIN, EMIT, DONE), q_mul function (Q16.16 multiply-shift).
- One sub-module, mac_unit: controls load_bias/accumulate/clear; owns acc and the activation stage.
- FSM, counters and address generation stay in layer_sequencer.

Test Plan:
- Basic, NUM_IN=2, NUM_OUT=2, ACT_RELU=1:
  - Stimulus: in = {0x00010000, 0x00020000}; w = {0x00008000, 0x00004000, 0xFFFF0000, 0x00000000}; b = {0x00004000, 0x00008000}; out_ready=1.
  - Response: result (idx0, 0x00014000) in cycle 5; (idx1, 0x00000000) in cycle 10; done in cycle 11 only; busy high cycles 1–11.
- ReLU off: same vectors with ACT_RELU=0 -> idx1 out_data = 0xFFFF8000.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles at each EMIT.
  - Response: out_valid, out_idx and out_data stable while stalled; rd_en=0 during stall; done in cycle 19.
- Start while busy: pulse start in cycle 3 -> no restart; sequence and done timing identical to the basic case.
- Async reset mid-MAC:
  - Stimulus: rst_n low in cycle 3 for 2 cycles, then start again.
  - Response: all outputs 0 immediately; fresh run gives the same results as the basic case.
- Wrap and edge case:
  - Stimulus: NUM_IN=1, in = 0x7FFF0000, w = 0x00020000, b = 0, ACT_RELU=0.
  - Response: product wraps to out_data = 0xFFFE0000; per-neuron latency is 4 cycles.
